// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Holds the data/address widths and the requester indices used by the arbiter.
package regfile_pkg;
   localparam int   XLEN     = 32;
   localparam int   ADDR_W   = 5;
   localparam int   NUM_REGS = 32;
   localparam logic REQ_ALU  = 1'b0;
   localparam logic REQ_MEM  = 1'b1;

   // One bit per requester, indexed by REQ_ALU / REQ_MEM.
   typedef logic [1:0] req_vec_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Each ready depends only on the other
// requester's valid and the last-grant pointer, never on its own valid.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  req_vec_t valid,
   output req_vec_t ready
);

   logic     last_r;
   req_vec_t ready_s;
   req_vec_t xfer_s;

   // A side wins when the other side is idle or the other side was granted last.
   always_comb begin
      ready_s = 2'b00;
      xfer_s  = 2'b00;
      if (rst) begin
         ready_s = 2'b00;
      end else begin
         ready_s[REQ_ALU] = !valid[REQ_MEM] || (last_r == REQ_MEM);
         ready_s[REQ_MEM] = !valid[REQ_ALU] || (last_r == REQ_ALU);
      end
      xfer_s = valid & ready_s;
   end

   assign ready = ready_s;

   // Last-grant pointer moves only on a completed transfer; reset favours the ALU.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r <= REQ_MEM;
      end else if (xfer_s[REQ_MEM]) begin
         last_r <= REQ_MEM;
      end else if (xfer_s[REQ_ALU]) begin
         last_r <= REQ_ALU;
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and load-unit writebacks into one register-file
// write port. Optional read bypass enabled by macro REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int XLEN   = regfile_pkg::XLEN,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [XLEN-1:0]   mem_data,
   output logic [ADDR_W-1:0] regw_addr,
   output logic [XLEN-1:0]   write_data,
   output logic              write_ena,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic [ADDR_W-1:0] reg1_addr,
   output logic [ADDR_W-1:0] reg2_addr,
   input  logic [XLEN-1:0]   reg1_data,
   input  logic [XLEN-1:0]   reg2_data,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data
);

   req_vec_t          valid_s;
   req_vec_t          ready_s;
   logic              xfer_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [XLEN-1:0]   sel_data_s;

   assign valid_s[REQ_ALU] = alu_valid;
   assign valid_s[REQ_MEM] = mem_valid;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .valid (valid_s),
      .ready (ready_s)
   );

   assign alu_ready = ready_s[REQ_ALU];
   assign mem_ready = ready_s[REQ_MEM];
   assign reg1_addr = rs1_addr;
   assign reg2_addr = rs2_addr;

   // Select the transferring request; at most one side transfers per cycle.
   always_comb begin
      xfer_s     = 1'b0;
      sel_addr_s = alu_addr;
      sel_data_s = alu_data;
      if (alu_valid && ready_s[REQ_ALU]) begin
         xfer_s = 1'b1;
      end else if (mem_valid && ready_s[REQ_MEM]) begin
         xfer_s     = 1'b1;
         sel_addr_s = mem_addr;
         sel_data_s = mem_data;
      end else begin
         xfer_s = 1'b0;
      end
   end

   // Write-port register; writes to x0 are accepted but never enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_ena  <= 1'b0;
         regw_addr  <= {ADDR_W{1'b0}};
         write_data <= {XLEN{1'b0}};
      end else if (xfer_s) begin
         write_ena  <= (sel_addr_s != {ADDR_W{1'b0}});
         regw_addr  <= sel_addr_s;
         write_data <= sel_data_s;
      end else begin
         write_ena  <= 1'b0;
         regw_addr  <= regw_addr;
         write_data <= write_data;
      end
   end

   // Read-data delivery: x0 always reads zero, optional forward of the in-flight write.
   always_comb begin
      rs1_data = reg1_data;
      rs2_data = reg2_data;
      if (rs1_addr == {ADDR_W{1'b0}}) begin
         rs1_data = {XLEN{1'b0}};
`ifdef REGFILE_WB_BYPASS_EN
      end else if (write_ena && (regw_addr == rs1_addr)) begin
         rs1_data = write_data;
`endif
      end else begin
         rs1_data = reg1_data;
      end
      if (rs2_addr == {ADDR_W{1'b0}}) begin
         rs2_data = {XLEN{1'b0}};
`ifdef REGFILE_WB_BYPASS_EN
      end else if (write_ena && (regw_addr == rs2_addr)) begin
         rs2_data = write_data;
`endif
      end else begin
         rs2_data = reg2_data;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (either bypass build).
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        alu_valid, alu_ready, mem_valid, mem_ready;
   logic [4:0]  alu_addr, mem_addr, regw_addr, rs1_addr, rs2_addr, reg1_addr, reg2_addr;
   logic [31:0] alu_data, mem_data, write_data, reg1_data, reg2_data, rs1_data, rs2_data;
   logic        write_ena;

   int n_cmp = 0;
   int n_err = 0;

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .regw_addr(regw_addr), .write_data(write_data), .write_ena(write_ena),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
      .reg1_data(reg1_data), .reg2_data(reg2_data), .rs1_data(rs1_data), .rs2_data(rs2_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;  logic [4:0] aa; logic [31:0] ad;
      logic        mv;  logic [4:0] ma; logic [31:0] md;
      logic [4:0]  r1a; logic [31:0] r1d; logic [4:0] r2a; logic [31:0] r2d;
      logic        e_ar; logic e_mr;
      logic [31:0] e_r1b; logic [31:0] e_r1n; logic [31:0] e_r2b; logic [31:0] e_r2n;
      logic        e_we; logic chk_port; logic [4:0] e_wa; logic [31:0] e_wd;
   } vec_t;

   vec_t vec [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //           av   aa    ad            mv   ma    md            r1a   r1d           r2a   r2d           ar   mr   r1b           r1n           r2b           r2n           we   chk  wa    wd
      vec[0] = '{1'b1,5'd1,32'h0000FFFF,1'b0,5'd0,32'h0,       5'd0,32'h12345678,5'd7,32'hA5A5A5A5,1'b1,1'b0,32'h0,       32'h0,       32'hA5A5A5A5,32'hA5A5A5A5,1'b1,1'b1,5'd1,32'h0000FFFF};
      vec[1] = '{1'b1,5'd2,32'h22,      1'b1,5'd3,32'h33,      5'd1,32'h0,       5'd0,32'hFFFFFFFF,1'b0,1'b1,32'h0000FFFF,32'h0,       32'h0,       32'h0,       1'b1,1'b1,5'd3,32'h33};
      vec[2] = '{1'b1,5'd2,32'h22,      1'b1,5'd3,32'h33,      5'd3,32'h11,      5'd3,32'h44,      1'b1,1'b0,32'h33,      32'h11,      32'h33,      32'h44,      1'b1,1'b1,5'd2,32'h22};
      vec[3] = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       5'd2,32'h55,      5'd5,32'h66,      1'b1,1'b1,32'h22,      32'h55,      32'h66,      32'h66,      1'b0,1'b1,5'd2,32'h22};
      vec[4] = '{1'b0,5'd0,32'h0,       1'b1,5'd0,32'hDEADBEEF,5'd2,32'h77,      5'd0,32'h88,      1'b0,1'b1,32'h77,      32'h77,      32'h0,       32'h0,       1'b0,1'b0,5'd0,32'h0};
      vec[5] = '{1'b1,5'd4,32'h44440000,1'b1,5'd6,32'h6,       5'd4,32'h9,       5'd0,32'h1,       1'b1,1'b0,32'h9,       32'h9,       32'h0,       32'h0,       1'b1,1'b1,5'd4,32'h44440000};
      vec[6] = '{1'b1,5'd5,32'hFFFF0000,1'b0,5'd0,32'h0,       5'd4,32'h0,       5'd9,32'h2,       1'b1,1'b1,32'h44440000,32'h0,       32'h2,       32'h2,       1'b1,1'b1,5'd5,32'hFFFF0000};
      vec[7] = '{1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,       5'd5,32'h0,       5'd5,32'h1,       1'b1,1'b1,32'hFFFF0000,32'h0,       32'hFFFF0000,32'h1,       1'b0,1'b1,5'd5,32'hFFFF0000};

      // Reset with requests pending: nothing may be accepted.
      rst = 1'b1;
      alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h8;
      mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h9;
      rs1_addr = 5'd0; rs2_addr = 5'd0; reg1_data = 32'h0; reg2_data = 32'h0;
      #1;
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
      tick(); tick();
      chk("rst_we",    {31'd0, write_ena}, 32'd0);
      chk("rst_waddr", {27'd0, regw_addr}, 32'd0);
      chk("rst_wdata", write_data, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         alu_valid = vec[i].av; alu_addr = vec[i].aa; alu_data = vec[i].ad;
         mem_valid = vec[i].mv; mem_addr = vec[i].ma; mem_data = vec[i].md;
         rs1_addr = vec[i].r1a; reg1_data = vec[i].r1d;
         rs2_addr = vec[i].r2a; reg2_data = vec[i].r2d;
         #1;
         chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vec[i].e_ar});
         chk($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vec[i].e_mr});
         chk($sformatf("v%0d_rs1", i), rs1_data, BYP ? vec[i].e_r1b : vec[i].e_r1n);
         chk($sformatf("v%0d_rs2", i), rs2_data, BYP ? vec[i].e_r2b : vec[i].e_r2n);
         chk($sformatf("v%0d_reg1_addr", i), {27'd0, reg1_addr}, {27'd0, vec[i].r1a});
         tick();
         chk($sformatf("v%0d_we", i), {31'd0, write_ena}, {31'd0, vec[i].e_we});
         if (vec[i].chk_port) begin
            chk($sformatf("v%0d_waddr", i), {27'd0, regw_addr}, {27'd0, vec[i].e_wa});
            chk($sformatf("v%0d_wdata", i), write_data, vec[i].e_wd);
         end
      end

      // Transfer accepted, then reset arrives: the write is dropped.
      alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99;
      mem_valid = 1'b0;
      #1;
      chk("rb_alu_ready", {31'd0, alu_ready}, 32'd1);
      tick();
      chk("rb_we_pre", {31'd0, write_ena}, 32'd1);
      rst = 1'b1; mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'hB;
      #1;
      chk("rb_alu_ready_rst", {31'd0, alu_ready}, 32'd0);
      chk("rb_mem_ready_rst", {31'd0, mem_ready}, 32'd0);
      tick();
      chk("rb_we_post",    {31'd0, write_ena}, 32'd0);
      chk("rb_waddr_post", {27'd0, regw_addr}, 32'd0);
      chk("rb_wdata_post", write_data, 32'd0);
      tick();
      rst = 1'b0; alu_addr = 5'd10; alu_data = 32'hA;
      #1;
      chk("rb_conflict_alu", {31'd0, alu_ready}, 32'd1);
      chk("rb_conflict_mem", {31'd0, mem_ready}, 32'd0);
      tick();
      chk("rb_we_first",    {31'd0, write_ena}, 32'd1);
      chk("rb_waddr_first", {27'd0, regw_addr}, 32'd10);

      // Sustained conflict after a fresh reset alternates ALU, MEM, ALU, MEM.
      alu_valid = 1'b0; mem_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h1111;
      mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h3333;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rr%0d_alu_ready", k), {31'd0, alu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("rr%0d_mem_ready", k), {31'd0, mem_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
         tick();
         chk($sformatf("rr%0d_we", k),    {31'd0, write_ena}, 32'd1);
         chk($sformatf("rr%0d_waddr", k), {27'd0, regw_addr}, (k % 2 == 0) ? 32'd2 : 32'd3);
         chk($sformatf("rr%0d_wdata", k), write_data, (k % 2 == 0) ? 32'h1111 : 32'h3333);
      end
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      chk("idle_we", {31'd0, write_ena}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every write and read data port.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (32 architectural registers).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports alu_valid/alu_ready  input/output  1/1  requester 0 (ALU) writeback handshake.
REQ-007 SHALL have ports alu_addr/alu_data  input  ADDR_W/XLEN  requester 0 destination register and value.
REQ-008 SHALL have ports mem_valid/mem_ready  input/output  1/1  requester 1 (load unit) writeback handshake.
REQ-009 SHALL have ports mem_addr/mem_data  input  ADDR_W/XLEN  requester 1 destination register and value.
REQ-010 SHALL have ports regw_addr/write_data/write_ena  output  ADDR_W/XLEN/1  register file write port.
REQ-011 SHALL have ports rs1_addr/rs2_addr  input  ADDR_W  consumer read addresses, also driven to reg1_addr/reg2_addr outputs.
REQ-012 SHALL have ports reg1_data/reg2_data  input  XLEN  raw register file read data.
REQ-013 SHALL have ports rs1_data/rs2_data  output  XLEN  read data delivered to consumer.

Function
REQ-014 SHALL transfer a request when valid and ready are both high at a rising edge; ready SHALL NOT depend on the same requester's valid.
REQ-015 SHALL grant at most one requester per cycle; ready is high only for the granted requester.
REQ-016 SHALL grant a lone valid requester in the same cycle (ready high combinationally).
REQ-017 SHALL resolve simultaneous valids round-robin: the requester not granted most recently wins; last-grant pointer updates only on a completed transfer.
REQ-018 SHALL hold the last-grant pointer unchanged when no transfer occurs.
REQ-019 SHALL register the accepted request: write_ena, regw_addr, write_data at cycle N+1 for a transfer at cycle N (latency 1).
REQ-020 SHALL accept a request to address 0 (ready high) but keep write_ena low in the following cycle.
REQ-021 SHALL keep write_ena low in any cycle following no transfer; regw_addr/write_data hold their last values.
REQ-022 SHALL sustain one write per cycle with back-to-back transfers and no bubble.
REQ-023 SHALL, with bypass compiled in, drive rsX_data = write_data when write_ena is high, regw_addr == rsX_addr and rsX_addr != 0; otherwise rsX_data = regX_data.
REQ-024 SHALL drive rs1_data/rs2_data as 0 whenever rsX_addr == 0, regardless of regX_data.

Reset
REQ-025 SHALL, while rst is high at a rising edge, clear write_ena, regw_addr, write_data to 0 and set the last-grant pointer so requester 0 wins the next conflict.
REQ-026 SHALL hold alu_ready and mem_ready low while rst is high; a request pending during reset is not consumed.
REQ-027 SHALL discard a transfer accepted in the cycle before rst rises: write_ena is low in the cycle following the reset edge.

Configuration
REQ-028 SHALL compile the read bypass of REQ-023 only when macro REGFILE_WB_BYPASS_EN is defined.
REQ-029 SHALL, without REGFILE_WB_BYPASS_EN, drive rsX_data = regX_data (REQ-024 zero rule still applies); all other behaviour is identical.

Structure
REQ-030 SHALL take XLEN, ADDR_W, register count and requester index constants (REQ_ALU=0, REQ_MEM=1) from shared package regfile_pkg.
REQ-031 SHALL implement grant logic and the last-grant pointer in sub-module rr_arbiter2; the write-port register and bypass stay in the top module.

Verification
REQ-032 SHALL cover: alu_valid only, addr 1, data 0x0000FFFF at cycle N -> alu_ready high at N; write_ena=1, regw_addr=1, write_data=0x0000FFFF at N+1.
REQ-033 SHALL cover: both valid for 4 cycles after reset (alu addr 2, mem addr 3) -> grants ALU, MEM, ALU, MEM; writes to 2,3,2,3 on consecutive cycles.
REQ-034 SHALL cover: mem_valid, addr 0, data 0xDEADBEEF -> mem_ready high; write_ena stays 0 next cycle.
REQ-035 SHALL cover: with REGFILE_WB_BYPASS_EN, write to reg 5 = 0xFFFF0000 in flight, rs1_addr=5, reg1_data=0x0 -> rs1_data=0xFFFF0000; without macro -> rs1_data=0x0.
REQ-036 SHALL cover: transfer accepted at N, rst high at N+1 -> write_ena=0, outputs 0, both ready low during reset; first conflict after reset granted to ALU.
